// File: rtl/gb_ppu_pkg.sv
// Shared types and constants for the GameBoy PPU pixel path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gb_ppu_pkg;

  localparam int LCD_WIDTH_DEF = 160;
  localparam int FIFO_DEPTH    = 16;

  // 2-bit background colour index as stored in the pixel FIFO
  typedef logic [1:0] pix_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } ppu_state_t;

endpackage

// File: rtl/gb_bgp_map.sv
// Background palette lookup: colour index + BGP register -> 2-bit shade.
// Latency: combinational.
// Backpressure: none.
// Ports: idx (colour index), bgp (palette register), shade (output shade).
// With GB_PIXEL_FIFO_PALETTE_EN defined the shade comes from bgp; without it
// the raw index passes straight through and bgp is ignored.
module gb_bgp_map
  import gb_ppu_pkg::*;
(
  input  pix_idx_t   idx,
  input  logic [7:0] bgp,
  output logic [1:0] shade
);

`ifdef GB_PIXEL_FIFO_PALETTE_EN
  always_comb begin
    shade = bgp[1:0];
    unique case (idx)
      2'd0: shade = bgp[1:0];
      2'd1: shade = bgp[3:2];
      2'd2: shade = bgp[5:4];
      2'd3: shade = bgp[7:6];
    endcase
  end
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign shade      = idx;
`endif

endmodule

// File: rtl/gb_pixel_fifo.sv
// Background pixel FIFO: takes 8-pixel tile rows, drops SCX fine-scroll
// pixels, and emits one shaded pixel per cycle for one LCD line.
// Latency: pop in cycle c shows on LD/PX_VALID in c+1; a row accepted into an
// empty FIFO with no scroll reaches PX_VALID two cycles later.
// Backpressure: row_ready is high only while busy with room for a full row
// (count <= 8); an empty FIFO stalls output (PX_VALID low, pix_x held).
// Ports: clk, reset_n (async active-low), line_start/scx_fine (new line),
//   bgp (palette), row_valid/row_lo/row_hi/row_ready (tile row input),
//   LD/PX_VALID/pix_x/line_done (pixel output), busy (DISCARD or SHIFT).
// Optional macro: GB_PIXEL_FIFO_PALETTE_EN (palette lookup on LD).
module gb_pixel_fifo
  import gb_ppu_pkg::*;
#(
  parameter int LCD_WIDTH = LCD_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_start,
  input  logic [2:0] scx_fine,
  input  logic [7:0] bgp,
  input  logic       row_valid,
  input  logic [7:0] row_lo,
  input  logic [7:0] row_hi,
  output logic       row_ready,
  output logic [1:0] LD,
  output logic       PX_VALID,
  output logic [7:0] pix_x,
  output logic       line_done,
  output logic       busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ppu_state_t       state, state_nxt;
  pix_idx_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [2:0]       discard;
  logic             armed;
  logic             start, push, pop, last_px;
  logic [1:0]       shade;

  // line_start is blocked until one clock edge has passed since reset release
  assign start     = line_start && armed;
  assign busy      = (state == DISCARD) || (state == SHIFT);
  assign row_ready = busy && (count <= CNT_W'(8));
  // a line_start cycle flushes instead of moving data
  assign push      = row_valid && row_ready && !start;
  assign pop       = busy && (count != CNT_W'(0)) && !start;
  assign last_px   = (state == SHIFT) && (pix_x == 8'(LCD_WIDTH - 1));

  gb_bgp_map u_bgp_map (
    .idx   (fifo_mem[rd_ptr]),
    .bgp   (bgp),
    .shade (shade)
  );

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (scx_fine != 3'd0) ? DISCARD : SHIFT;
    end else begin
      case (state)
        DISCARD: if (pop && discard == 3'd1) state_nxt = SHIFT;
        SHIFT:   if (pop && last_px)         state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Storage needs no reset: count/pointers decide what is valid.
  // Entry 0 of a row is its leftmost pixel (bit 7) and leaves first.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        fifo_mem[wr_ptr + PTR_W'(i)] <= {row_hi[7-i], row_lo[7-i]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      discard <= '0;
      pix_x   <= '0;
    end else if (start) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      discard <= scx_fine;
      pix_x   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(8);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (push ? CNT_W'(8) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
      if (pop && state == DISCARD) discard <= discard - 3'd1;
      // pix_x parks on the last column so it reads LCD_WIDTH-1 with line_done
      if (pop && state == SHIFT && !last_px) pix_x <= pix_x + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      LD        <= '0;
      PX_VALID  <= 1'b0;
      line_done <= 1'b0;
    end else begin
      PX_VALID  <= pop && (state == SHIFT);
      line_done <= pop && last_px;
      if (pop && state == SHIFT) LD <= shade;
    end
  end

endmodule
